fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches words from instruction memory into a
// 2-entry {instr, pc} queue and presents the head entry to decode. Taken
// branches from decode flush the queue and redirect fetch to the target.
//
// Handshakes:
//   imem side   - imem_req/imem_addr are held stable from the cycle the request
//                 rises until the cycle imem_ack is seen with imem_req high; that
//                 cycle is the one and only transfer, and imem_rdata is sampled
//                 only then. At most one request is ever outstanding.
//   decode side - instr_valid acts as valid and dec_ready as ready; the head
//                 entry is consumed in every cycle where both are high, and
//                 pcsrc/immext are only looked at in such a cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        instr_valid,
    input  logic        dec_ready,
    input  logic        pcsrc,
    input  logic [31:0] immext,
    output logic [1:0]  fsm_state
);

    // IDLE : single settling cycle after reset release
    // FETCH: normal operation, requests issued while the queue has room
    // DRAIN: a redirect hit while a request was in flight; wait for its ack,
    //        throw the word away, then restart fetching at the latched target
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [31:0] instr_mem [2];
    logic [31:0] pc_mem    [2];

    logic        transfer;
    logic        pop;
    logic        redirect;
    logic        push;
    logic        flush;
    logic [31:0] redirect_target;

    // Handshake and queue control terms
    assign transfer        = req_q & imem_ack;
    assign instr_valid     = (count_q != 2'd0);
    assign pop             = instr_valid & dec_ready;
    assign redirect        = pop & pcsrc;
    assign flush           = redirect;
    // Data from a transfer that coincides with a redirect is stale: never queue it
    assign push            = (state_q == FETCH) & transfer & ~redirect;
    assign redirect_target = (pc + immext) & 32'hFFFF_FFFC;

    // Queue occupancy for the next cycle; a flush wins over push/pop
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state, request and fetch address logic
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    if (req_q && !imem_ack) begin
                        // Request still in flight: keep it as is and drain it
                        state_d  = DRAIN;
                        target_d = redirect_target;
                    end else begin
                        // Nothing in flight (or it just completed): restart now
                        fetch_pc_d = redirect_target;
                        req_d      = 1'b1;
                    end
                end else if (transfer) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    req_d      = (count_d < 2'd2);
                end else if (!req_q) begin
                    req_d = (count_d < 2'd2);
                end
            end
            DRAIN: begin
                if (transfer) begin
                    fetch_pc_d = target_q;
                    req_d      = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            count_q    <= count_d;
        end
    end

    // Queue storage and pointers; a flush empties the queue by rewinding both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_mem[i] <= 32'd0;
                pc_mem[i]    <= 32'd0;
            end
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr_q] <= imem_rdata;
                pc_mem[wr_ptr_q]    <= fetch_pc_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Outputs come straight from registers: head entry and request state
    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;
    assign instr     = instr_mem[rd_ptr_q];
    assign pc        = pc_mem[rd_ptr_q];
    assign op        = instr[6:0];
    assign pcplus4   = pc + 32'd4;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder plus
// a linear sequence of steps with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        dec_ready;
    logic        pcsrc;
    logic [31:0] immext;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int age = 0;
    int xfer_cnt = 0;
    bit ack_always = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .op         (op),
        .pc         (pc),
        .pcplus4    (pcplus4),
        .instr_valid(instr_valid),
        .dec_ready  (dec_ready),
        .pcsrc      (pcsrc),
        .immext     (immext),
        .fsm_state  (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory contents: a word derived from its address, opcode 7'h33
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[26:2], 7'h33};
    endfunction

    // Memory responder: acks a request after it has been up for 'lat' cycles
    always @(negedge clk) begin
        if (ack_always) begin
            imem_ack = 1'b1;
        end else if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            age      = 0;
        end else begin
            imem_ack = (age >= lat);
            age      = imem_ack ? 0 : age + 1;
        end
        imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;
        if (imem_ack && imem_req && rst_n) xfer_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset pulse; returns just after the release (IDLE cycle in progress)
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        xfer_cnt = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; dec_ready = 1'b0; pcsrc = 1'b0; immext = 32'd0; lat = 1;
        step(); step();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc",    pc, 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);

        // Streaming: ack one cycle after each request, decode always ready
        dec_ready = 1'b1;
        rst_n = 1'b1;
        chk("a_idle",   32'(fsm_state), 32'd0);
        step();
        chk("a_fetch",  32'(fsm_state), 32'd1);
        chk("a_req_n1", 32'(imem_req), 32'd0);
        step();
        chk("a_req_n2", 32'(imem_req), 32'd1);
        chk("a_addr0",  imem_addr, 32'h0);
        step();
        chk("a_hold_addr",  imem_addr, 32'h0);
        chk("a_valid_n3",   32'(instr_valid), 32'd0);
        step();
        chk("a_valid_n4",   32'(instr_valid), 32'd1);
        chk("a_pc0",        pc, 32'h0);
        chk("a_instr0",     instr, word(32'h0));
        chk("a_op0",        32'(op), 32'h33);
        chk("a_pcplus4",    pcplus4, 32'h4);
        chk("a_addr4",      imem_addr, 32'h4);
        step();
        chk("a_valid_n5",   32'(instr_valid), 32'd0);
        step();
        chk("a_pc4",        pc, 32'h4);
        step();
        step();
        chk("a_pc8",        pc, 32'h8);
        chk("a_valid_n8",   32'(instr_valid), 32'd1);

        // Back-pressure: queue fills after two transfers, request stops
        lat = 0; dec_ready = 1'b0; pcsrc = 1'b0;
        do_reset();
        repeat (6) step();
        chk("b_xfers",   32'(xfer_cnt), 32'd2);
        chk("b_req_off", 32'(imem_req), 32'd0);
        chk("b_head0",   pc, 32'h0);
        dec_ready = 1'b1;
        step();
        chk("b_head4",   pc, 32'h4);
        chk("b_req_on",  32'(imem_req), 32'd1);
        chk("b_addr8",   imem_addr, 32'h8);

        // pcsrc without ready is ignored; redirect to 0x10, then back to 0x08
        lat = 0; dec_ready = 1'b0; pcsrc = 1'b0;
        do_reset();
        repeat (5) step();
        pcsrc = 1'b1; immext = 32'h10;
        step();
        chk("c_noeff_pc",   pc, 32'h0);
        chk("c_noeff_addr", imem_addr, 32'h8);
        chk("c_noeff_req",  32'(imem_req), 32'd0);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0; pcsrc = 1'b0;
        chk("c_flush1",     32'(instr_valid), 32'd0);
        chk("c_addr10",     imem_addr, 32'h10);
        step();
        step();
        chk("c_head10",     pc, 32'h10);
        chk("c_full_req",   32'(imem_req), 32'd0);
        chk("c_instr10",    instr, word(32'h10));
        dec_ready = 1'b1; pcsrc = 1'b1; immext = 32'hFFFF_FFF8;
        step();
        pcsrc = 1'b0;
        chk("c_flush2",     32'(instr_valid), 32'd0);
        chk("c_addr08",     imem_addr, 32'h8);
        step();
        chk("c_head08",     pc, 32'h8);
        chk("c_instr08",    instr, word(32'h8));

        // Redirect while the 0x14 request is pending and its ack is slow
        lat = 0; dec_ready = 1'b0; pcsrc = 1'b0;
        do_reset();
        repeat (5) step();
        pcsrc = 1'b1; immext = 32'h10;
        step();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0; pcsrc = 1'b0; lat = 3;
        step();
        chk("d_head10",   pc, 32'h10);
        chk("d_addr14",   imem_addr, 32'h14);
        step();
        dec_ready = 1'b1; pcsrc = 1'b1; immext = 32'h20;
        step();
        immext = 32'h100;
        chk("d_drain",    32'(fsm_state), 32'd2);
        chk("d_hold14a",  imem_addr, 32'h14);
        chk("d_reqhold",  32'(imem_req), 32'd1);
        chk("d_novalid",  32'(instr_valid), 32'd0);
        step();
        lat = 0;
        chk("d_drain2",   32'(fsm_state), 32'd2);
        chk("d_hold14b",  imem_addr, 32'h14);
        step();
        pcsrc = 1'b0; dec_ready = 1'b0;
        chk("d_back",     32'(fsm_state), 32'd1);
        chk("d_addr30",   imem_addr, 32'h30);
        chk("d_discard",  32'(instr_valid), 32'd0);
        step();
        chk("d_head30",   pc, 32'h30);
        chk("d_instr30",  instr, word(32'h30));

        // Address wrap at the top of memory
        lat = 0; dec_ready = 1'b0; pcsrc = 1'b0;
        do_reset();
        repeat (5) step();
        dec_ready = 1'b1; pcsrc = 1'b1; immext = 32'hFFFF_FFFC;
        step();
        dec_ready = 1'b0; pcsrc = 1'b0;
        chk("e_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("e_head_top", pc, 32'hFFFF_FFFC);
        chk("e_pcplus4",  pcplus4, 32'h0);
        chk("e_wrap",     imem_addr, 32'h0);
        chk("e_instr",    instr, word(32'hFFFF_FFFC));

        // Asynchronous reset mid-request with one entry queued
        lat = 1; dec_ready = 1'b0; pcsrc = 1'b0;
        do_reset();
        repeat (4) step();
        chk("f_pre_valid", 32'(instr_valid), 32'd1);
        chk("f_pre_req",   32'(imem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        ack_always = 1'b1;
        #1;
        chk("f_async_req",   32'(imem_req), 32'd0);
        chk("f_async_valid", 32'(instr_valid), 32'd0);
        chk("f_async_state", 32'(fsm_state), 32'd0);
        chk("f_async_addr",  imem_addr, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("f_ack_ignored", 32'(instr_valid), 32'd0);
        chk("f_req_low",     32'(imem_req), 32'd0);
        step();
        chk("f_first_addr",  imem_addr, 32'h0);
        chk("f_first_req",   32'(imem_req), 32'd1);
        step();
        chk("f_first_pc",    pc, 32'h0);
        chk("f_first_valid", 32'(instr_valid), 32'd1);
        ack_always = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
